// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator.
// Every output is registered from the next raster position.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk_pxl_i,
  input  logic       reset_n_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       visible_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_B   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_E   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_B   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_E   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_win;
  logic       vs_win;

  always_comb begin
    x_nxt = x_o + 10'd1;
    y_nxt = y_o;
    if (x_o == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_o == V_LAST) ? '0 : y_o + 10'd1;
    end
  end

  assign hs_win = (x_nxt >= HS_B) && (x_nxt < HS_E);
  assign vs_win = (y_nxt >= VS_B) && (y_nxt < VS_E);

  // Reset parks on the last pixel so release lands on (0,0).
  always_ff @(posedge clk_pxl_i) begin
    if (!reset_n_i) begin
      x_o           <= H_LAST;
      y_o           <= V_LAST;
      visible_o     <= 1'b0;
      hsync_o       <= ~SYNC_ACTIVE;
      vsync_o       <= ~SYNC_ACTIVE;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      x_o           <= x_nxt;
      y_o           <= y_nxt;
      visible_o     <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      hsync_o       <= hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_o       <= vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start_o  <= (x_nxt == '0);
      frame_start_o <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three geometries checked against a
// raster-index model plus literal expectations.
module tb_vga_timing_gen;

  logic clk;
  logic rst [3];
  logic [9:0] xo [3];
  logic [9:0] yo [3];
  logic vis [3];
  logic hs [3];
  logic vs [3];
  logic ls [3];
  logic fs [3];

  int n_chk  = 0;
  int n_fail = 0;

  int HV [3] = '{640, 64, 4};
  int HF [3] = '{16, 4, 1};
  int HSW[3] = '{96, 8, 2};
  int HB [3] = '{48, 4, 1};
  int VV [3] = '{480, 48, 3};
  int VF [3] = '{10, 2, 1};
  int VSW[3] = '{2, 2, 1};
  int VB [3] = '{33, 3, 1};

  int  t    [3];
  bit  valid[3] = '{0, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk_pxl_i(clk), .reset_n_i(rst[0]),
    .x_o(xo[0]), .y_o(yo[0]), .visible_o(vis[0]),
    .hsync_o(hs[0]), .vsync_o(vs[0]),
    .line_start_o(ls[0]), .frame_start_o(fs[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_med (
    .clk_pxl_i(clk), .reset_n_i(rst[1]),
    .x_o(xo[1]), .y_o(yo[1]), .visible_o(vis[1]),
    .hsync_o(hs[1]), .vsync_o(vs[1]),
    .line_start_o(ls[1]), .frame_start_o(fs[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk_pxl_i(clk), .reset_n_i(rst[2]),
    .x_o(xo[2]), .y_o(yo[2]), .visible_o(vis[2]),
    .hsync_o(hs[2]), .vsync_o(vs[2]),
    .line_start_o(ls[2]), .frame_start_o(fs[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int htot(input int k);
    return HV[k] + HF[k] + HSW[k] + HB[k];
  endfunction

  function automatic int vtot(input int k);
    return VV[k] + VF[k] + VSW[k] + VB[k];
  endfunction

  // Model: position is a linear raster index within the frame.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst[k]) begin
        t[k] = htot(k) * vtot(k) - 1;
        valid[k] = 1'b1;
      end else if (valid[k]) begin
        t[k] = (t[k] + 1) % (htot(k) * vtot(k));
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid[k]) begin
        int x, y, hsb, vsb;
        x = t[k] % htot(k);
        y = t[k] / htot(k);
        hsb = HV[k] + HF[k];
        vsb = VV[k] + VF[k];
        chk($sformatf("x[%0d]", k), int'(xo[k]), x);
        chk($sformatf("y[%0d]", k), int'(yo[k]), y);
        chk($sformatf("vis[%0d]", k), int'(vis[k]),
            int'(x < HV[k] && y < VV[k]));
        chk($sformatf("hs[%0d]", k), int'(hs[k]),
            int'(!(x >= hsb && x < hsb + HSW[k])));
        chk($sformatf("vs[%0d]", k), int'(vs[k]),
            int'(!(y >= vsb && y < vsb + VSW[k])));
        chk($sformatf("ls[%0d]", k), int'(ls[k]), int'(x == 0));
        chk($sformatf("fs[%0d]", k), int'(fs[k]), int'(t[k] == 0));
      end
    end
  end

  task automatic measure_frame(input int k, output int per,
                               output int vsl, output int hsl);
    int n;
    per = 0; vsl = 0; hsl = 0; n = 0;
    while (fs[k] !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      per = -1;
      return;
    end
    do begin
      @(negedge clk);
      per++;
      if (vs[k] === 1'b0) vsl++;
      if (hs[k] === 1'b0) hsl++;
    end while (fs[k] !== 1'b1 && per < 20000);
  endtask

  initial begin
    int nvis, nhs, nls, per, vsl, hsl, n;
    int rcnt[3];
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("rst_x", int'(xo[0]), 799);
      chk("rst_y", int'(yo[0]), 524);
      chk("rst_vis", int'(vis[0]), 0);
      chk("rst_hs", int'(hs[0]), 1);
      chk("rst_vs", int'(vs[0]), 1);
      chk("rst_ls", int'(ls[0]), 0);
      chk("rst_fs", int'(fs[0]), 0);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    @(negedge clk);
    chk("rel_x", int'(xo[0]), 0);
    chk("rel_y", int'(yo[0]), 0);
    chk("rel_vis", int'(vis[0]), 1);
    chk("rel_fs", int'(fs[0]), 1);
    chk("rel_ls", int'(ls[0]), 1);
    nvis = 1; nhs = 0; nls = 1;
    for (int i = 0; i < 799; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rel1_x", int'(xo[0]), 1);
        chk("rel1_ls", int'(ls[0]), 0);
        chk("rel1_fs", int'(fs[0]), 0);
      end
      if (vis[0]) nvis++;
      if (!hs[0]) nhs++;
      if (ls[0]) nls++;
    end
    chk("line_vis_cnt", nvis, 640);
    chk("line_hs_cnt", nhs, 96);
    chk("line_ls_cnt", nls, 1);
    @(negedge clk);
    chk("line1_x", int'(xo[0]), 0);
    chk("line1_y", int'(yo[0]), 1);
    chk("line1_ls", int'(ls[0]), 1);

    measure_frame(2, per, vsl, hsl);
    chk("small_period", per, 48);
    chk("small_vs_cnt", vsl, 8);
    chk("small_hs_cnt", hsl, 12);
    measure_frame(1, per, vsl, hsl);
    chk("med_period", per, 4400);
    chk("med_vs_cnt", vsl, 160);
    chk("med_hs_cnt", hsl, 440);

    n = 0;
    while (!(xo[1] == 10'd30 && yo[1] == 10'd20) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_timeout", int'(n >= 5000), 0);
    rst[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    chk("mid_x", int'(xo[1]), 79);
    chk("mid_y", int'(yo[1]), 54);
    chk("mid_fs", int'(fs[1]), 0);
    @(negedge clk);
    chk("mid1_x", int'(xo[1]), 0);
    chk("mid1_y", int'(yo[1]), 0);
    chk("mid1_fs", int'(fs[1]), 1);

    for (int k = 0; k < 3; k++) rcnt[k] = 0;
    repeat (20000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rcnt[k] > 0) begin
          rcnt[k]--;
          rst[k] = 1'b0;
        end else if ($urandom_range(0, 599) == 0) begin
          rcnt[k] = int'($urandom_range(0, 2));
          rst[k] = 1'b0;
        end else begin
          rst[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 25.2 MHz pixel clock from the pixel clock generator.
- Produces 640x480@60 Hz VGA raster timing: horizontal/vertical sync, active-video flag, current pixel coordinates, and line/frame start strobes.
- Sits between the pixel clock source and the framebuffer/character renderer and the VGA output pins.
- All outputs are registered in the pixel clock domain.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- SYNC_ACTIVE, 1'b0, asserted level of hsync_o/vsync_o (VGA 640x480 uses negative sync)

Ports:
- clk_pxl_i  input  1  pixel clock, 25.2 MHz
- reset_n_i  input  1  reset, synchronous, active-low
- x_o  output  10  current horizontal position, 0..H_TOTAL-1
- y_o  output  10  current vertical position, 0..V_TOTAL-1
- visible_o  output  1  high when x_o < H_VISIBLE and y_o < V_VISIBLE
- hsync_o  output  1  horizontal sync, at SYNC_ACTIVE level during the sync window
- vsync_o  output  1  vertical sync, at SYNC_ACTIVE level during the sync window
- line_start_o  output  1  one-cycle pulse when x_o == 0
- frame_start_o  output  1  one-cycle pulse when x_o == 0 and y_o == 0

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
  - HS_BEGIN = H_VISIBLE + H_FRONT = 656; HS_END = HS_BEGIN + H_SYNC = 752.
  - VS_BEGIN = 490; VS_END = 492.
- Counters:
  - h counter increments every clk_pxl_i edge; wraps H_TOTAL-1 -> 0.
  - v counter increments only when h wraps; wraps V_TOTAL-1 -> 0 when h wraps at v = V_TOTAL-1.
  - Both counters are exactly 10 bits wide. Values never exceed H_TOTAL-1 / V_TOTAL-1.
- Zero-latency contract: every output is a flop, and every output describes the same (x_o, y_o) position in the same cycle. The implementation computes the next position and registers all decodes from it.
- Decodes, as functions of (x_o, y_o):
  - visible_o = (x_o < H_VISIBLE) && (y_o < V_VISIBLE)
  - hsync_o = SYNC_ACTIVE when HS_BEGIN <= x_o < HS_END, else ~SYNC_ACTIVE
  - vsync_o = SYNC_ACTIVE when VS_BEGIN <= y_o < VS_END, else ~SYNC_ACTIVE. vsync is driven for every pixel of those lines, regardless of x_o.
  - line_start_o = (x_o == 0); frame_start_o = (x_o == 0 && y_o == 0)
- Reset:
  - Takes effect on the clock edge when reset_n_i == 0.
  - Position is forced to the last pixel of the frame: x_o = H_TOTAL-1 (799), y_o = V_TOTAL-1 (524).
  - Outputs at that position: visible_o = 0, hsync_o = vsync_o = ~SYNC_ACTIVE, line_start_o = frame_start_o = 0.
  - Outputs hold these values every cycle while reset_n_i is low.
- Reset release: on the first edge with reset_n_i == 1 the position advances to (0,0). That same edge asserts frame_start_o, line_start_o and visible_o.
- Reset mid-frame: counters jump directly to (799,524) on the next edge. No partial line or frame completion. No sync glitch beyond returning to the inactive level.
- Strobes: line_start_o and frame_start_o are high for exactly one cycle per line / frame.
- Steady state: frame period is exactly H_TOTAL*V_TOTAL = 420000 cycles; line period is 800 cycles.
- No handshake. The block free-runs; downstream consumers sample outputs on the same clock.

Test Plan:
- Reset hold: drive reset_n_i = 0 for 5 cycles -> every cycle shows x_o = 799, y_o = 524, visible_o = 0, hsync_o = vsync_o = 1, both strobes 0.
- Reset release: release reset_n_i -> next cycle shows x_o = 0, y_o = 0, visible_o = 1, frame_start_o = 1, line_start_o = 1. The following cycle shows x_o = 1 and both strobes 0.
- Horizontal line: run one line on y = 0 ->
  - visible_o high for x 0..639, low for x 640..799;
  - hsync_o = 0 exactly for x 656..751 (96 cycles);
  - line_start_o pulses every 800 cycles.
- Vertical frame: run one full frame ->
  - vsync_o = 0 for all 1600 cycles of lines 490..491;
  - visible_o is never high for y >= 480;
  - y_o wraps 524 -> 0 together with x_o wrapping 799 -> 0;
  - consecutive frame_start_o pulses are exactly 420000 cycles apart.
- Mid-frame reset: assert reset_n_i = 0 at (x = 300, y = 200) for 1 cycle -> next cycle position is (799,524); the cycle after is (0,0) with frame_start_o = 1.
- Parameter override: H = 4/1/2/1, V = 3/1/1/1 -> H_TOTAL = 8, V_TOTAL = 6; hsync_o low at x 5..6; vsync_o low on y = 4; frame period 48 cycles.
